// File: rtl/systolic_pe_if.sv
// systolic_pe_if -- bundle of the systolic PE's data, control and result
// handshake signals.
//
// Parameters:
//   W      operand width
//   ACC_W  result width
//
// Signals:
//   a_in/a_vld_in, b_in/b_vld_in   west/north operands and their valids
//   mode, clear                    semiring select, abandon accumulation
//   a_out/a_vld_out, b_out/b_vld_out  registered east/south forwards
//   res/res_vld/res_rdy            result valid/ready handshake
//   ovr                            sticky overrun flag
//   res_flag                       wrap/clamp status (SYSTOLIC_PE_STATUS_EN only)
//
// Modports:
//   master  the side feeding operands and consuming results
//   slave   the processing element
interface systolic_pe_if #(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 16
);
    logic [W-1:0]     a_in;
    logic             a_vld_in;
    logic [W-1:0]     b_in;
    logic             b_vld_in;
    logic [1:0]       mode;
    logic             clear;
    logic [W-1:0]     a_out;
    logic             a_vld_out;
    logic [W-1:0]     b_out;
    logic             b_vld_out;
    logic [ACC_W-1:0] res;
    logic             res_vld;
    logic             res_rdy;
    logic             ovr;
`ifdef SYSTOLIC_PE_STATUS_EN
    logic             res_flag;
`endif

    modport master (
        output a_in, a_vld_in, b_in, b_vld_in, mode, clear, res_rdy,
        input  a_out, a_vld_out, b_out, b_vld_out, res, res_vld, ovr
`ifdef SYSTOLIC_PE_STATUS_EN
        , input res_flag
`endif
    );

    modport slave (
        input  a_in, a_vld_in, b_in, b_vld_in, mode, clear, res_rdy,
        output a_out, a_vld_out, b_out, b_vld_out, res, res_vld, ovr
`ifdef SYSTOLIC_PE_STATUS_EN
        , output res_flag
`endif
    );
endinterface

// File: rtl/systolic_pe.sv
// systolic_pe -- one W-bit processing element of the systolic grid.
//
// Forwards operand a east and operand b south with one cycle of latency,
// folds every valid (a,b) pair into a local accumulator under one of four
// semirings (wrap MAC, saturating MAC, min-plus, max-plus) and, after K
// pairs, presents the result through a valid/ready output register. The
// wavefront is never stalled: a result arriving while the previous one is
// still unconsumed overwrites it and sets the sticky ovr flag.
//
// Parameters:
//   W      operand width (unsigned)
//   ACC_W  accumulator/result width, >= 2*W
//   K      pairs per result, >= 1
//
// Ports:
//   clk    clock
//   reset  synchronous, active-high
//   bus    systolic_pe_if.slave (operands, forwards, mode/clear, result)
//
// Optional feature: define SYSTOLIC_PE_STATUS_EN to add bus.res_flag, set
// when any addition of the delivered result wrapped (mode 0) or clamped
// (mode 1); always 0 for the min/max modes.
module systolic_pe #(
    parameter int unsigned W     = 8,
    parameter int unsigned ACC_W = 16,
    parameter int unsigned K     = 8
) (
    input logic          clk,
    input logic          reset,
    systolic_pe_if.slave bus
);

    localparam int unsigned CNT_W = (K > 1) ? $clog2(K) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(K - 1);

    typedef enum logic [1:0] {
        MODE_WRAP = 2'd0,
        MODE_SAT  = 2'd1,
        MODE_MIN  = 2'd2,
        MODE_MAX  = 2'd3
    } mode_e;

    logic [W-1:0]     r_a_out;
    logic             r_a_vld_out;
    logic [W-1:0]     r_b_out;
    logic             r_b_vld_out;
    logic [CNT_W-1:0] r_cnt;
    mode_e            r_mode;
    logic [ACC_W-1:0] r_acc;
    logic [ACC_W-1:0] r_res;
    logic             r_res_vld;
    logic             r_ovr;

    logic             w_pair;
    logic             w_first;
    logic             w_last;
    logic             w_load;
    mode_e            w_mode;
    logic [2*W-1:0]   w_prod;
    logic [W:0]       w_sum;
    logic [ACC_W-1:0] w_term;
    logic [ACC_W:0]   w_add;
    logic [ACC_W-1:0] w_acc_next;

`ifdef SYSTOLIC_PE_STATUS_EN
    logic             r_flag_acc;
    logic             r_res_flag;
    logic             w_flag_next;
`endif

    always_comb begin
        w_pair  = bus.a_vld_in & bus.b_vld_in;
        w_first = (r_cnt == '0);
        w_last  = (r_cnt == LAST);
        w_load  = w_pair & ~bus.clear & w_last;

        // The first pair of a result uses the live mode; later pairs use
        // the mode latched on that first pair.
        w_mode  = w_first ? mode_e'(bus.mode) : r_mode;

        w_prod  = {{W{1'b0}}, bus.a_in} * {{W{1'b0}}, bus.b_in};
        w_sum   = {1'b0, bus.a_in} + {1'b0, bus.b_in};
        w_term  = ((w_mode == MODE_MIN) || (w_mode == MODE_MAX))
                  ? ACC_W'(w_sum) : ACC_W'(w_prod);

        // Extra top bit is the wrap/clamp indicator for modes 0/1.
        w_add   = {1'b0, r_acc} + {1'b0, w_term};

        w_acc_next = w_term;
`ifdef SYSTOLIC_PE_STATUS_EN
        w_flag_next = 1'b0;
`endif
        if (!w_first) begin
            unique case (r_mode)
                MODE_WRAP: begin
                    w_acc_next = w_add[ACC_W-1:0];
`ifdef SYSTOLIC_PE_STATUS_EN
                    w_flag_next = r_flag_acc | w_add[ACC_W];
`endif
                end
                MODE_SAT: begin
                    w_acc_next = w_add[ACC_W] ? '1 : w_add[ACC_W-1:0];
`ifdef SYSTOLIC_PE_STATUS_EN
                    w_flag_next = r_flag_acc | w_add[ACC_W];
`endif
                end
                MODE_MIN: w_acc_next = (w_term < r_acc) ? w_term : r_acc;
                MODE_MAX: w_acc_next = (w_term > r_acc) ? w_term : r_acc;
                default:  w_acc_next = w_term;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_a_out     <= '0;
            r_a_vld_out <= 1'b0;
            r_b_out     <= '0;
            r_b_vld_out <= 1'b0;
            r_cnt       <= '0;
            r_mode      <= MODE_WRAP;
            r_acc       <= '0;
            r_res       <= '0;
            r_res_vld   <= 1'b0;
            r_ovr       <= 1'b0;
`ifdef SYSTOLIC_PE_STATUS_EN
            r_flag_acc  <= 1'b0;
            r_res_flag  <= 1'b0;
`endif
        end else begin
            r_a_out     <= bus.a_in;
            r_a_vld_out <= bus.a_vld_in;
            r_b_out     <= bus.b_in;
            r_b_vld_out <= bus.b_vld_in;

            // clear outranks a same-cycle pair, including the K-th one.
            if (bus.clear) begin
                r_cnt <= '0;
            end else if (w_pair) begin
                if (w_first) begin
                    r_mode <= w_mode;
                end
                r_acc <= w_acc_next;
`ifdef SYSTOLIC_PE_STATUS_EN
                r_flag_acc <= w_flag_next;
`endif
                if (w_last) begin
                    r_cnt <= '0;
                    r_res <= w_acc_next;
`ifdef SYSTOLIC_PE_STATUS_EN
                    r_res_flag <= w_flag_next;
`endif
                end else begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            if (w_load) begin
                r_res_vld <= 1'b1;
                if (r_res_vld && !bus.res_rdy) begin
                    r_ovr <= 1'b1;
                end
            end else if (r_res_vld && bus.res_rdy) begin
                r_res_vld <= 1'b0;
            end
        end
    end

    assign bus.a_out     = r_a_out;
    assign bus.a_vld_out = r_a_vld_out;
    assign bus.b_out     = r_b_out;
    assign bus.b_vld_out = r_b_vld_out;
    assign bus.res       = r_res;
    assign bus.res_vld   = r_res_vld;
    assign bus.ovr       = r_ovr;
`ifdef SYSTOLIC_PE_STATUS_EN
    assign bus.res_flag  = r_res_flag;
`endif

endmodule

// File: tb/tb_systolic_pe.sv
// tb_systolic_pe -- directed plus randomized bench for systolic_pe
// (W=8, ACC_W=16, K=4). A transaction-level reference model collects the
// pairs of each result in a queue and folds them with plain integer
// arithmetic once K have arrived.
module tb_systolic_pe;

    localparam int unsigned W     = 8;
    localparam int unsigned ACC_W = 16;
    localparam int unsigned K     = 4;
    localparam longint      SPAN  = 65536;

    typedef struct {
        int a;
        int b;
    } pair_t;

    logic clk = 1'b0;
    logic reset;

    systolic_pe_if #(.W(W), .ACC_W(ACC_W)) bus ();

    systolic_pe #(.W(W), .ACC_W(ACC_W), .K(K)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // reference-model state
    pair_t mq[$];
    int    lmode = 0;
    int    e_aout = 0, e_bout = 0, e_res = 0;
    bit    e_avld = 0, e_bvld = 0, e_vld = 0, e_ovr = 0, e_flag = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Fold the K collected pairs under the latched mode.
    function automatic void fold(output int r, output bit f);
        longint tot = 0;
        int     mn  = 1 << 30;
        int     mx  = -1;
        int     t;
        foreach (mq[i]) begin
            t = (lmode >= 2) ? (mq[i].a + mq[i].b) : (mq[i].a * mq[i].b);
            tot += t;
            if (t < mn) mn = t;
            if (t > mx) mx = t;
        end
        case (lmode)
            0:       begin r = int'(tot % SPAN);           f = (tot >= SPAN);   end
            1:       begin r = (tot > SPAN - 1) ? int'(SPAN - 1) : int'(tot);
                           f = (tot > SPAN - 1); end
            2:       begin r = mn; f = 1'b0; end
            default: begin r = mx; f = 1'b0; end
        endcase
    endfunction

    // Advance the model by one clock edge using the inputs now applied.
    task automatic model_edge();
        int r;
        bit f;
        bit load;
        if (reset) begin
            e_aout = 0; e_avld = 0; e_bout = 0; e_bvld = 0;
            e_res = 0; e_vld = 0; e_ovr = 0; e_flag = 0;
            lmode = 0;
            mq.delete();
        end else begin
            e_aout = int'(bus.a_in);  e_avld = bus.a_vld_in;
            e_bout = int'(bus.b_in);  e_bvld = bus.b_vld_in;
            load = 1'b0;
            r = 0;
            f = 1'b0;
            if (bus.clear) begin
                mq.delete();
            end else if (bus.a_vld_in && bus.b_vld_in) begin
                if (mq.size() == 0) lmode = int'(bus.mode);
                mq.push_back('{int'(bus.a_in), int'(bus.b_in)});
                if (mq.size() == K) begin
                    fold(r, f);
                    load = 1'b1;
                    mq.delete();
                end
            end
            if (load) begin
                if (e_vld && !bus.res_rdy) e_ovr = 1'b1;
                e_res = r; e_vld = 1'b1; e_flag = f;
            end else if (e_vld && bus.res_rdy) begin
                e_vld = 1'b0;
            end
        end
    endtask

    task automatic check_all();
        chk("a_out",     32'(bus.a_out),     32'(e_aout));
        chk("a_vld_out", 32'(bus.a_vld_out), 32'(e_avld));
        chk("b_out",     32'(bus.b_out),     32'(e_bout));
        chk("b_vld_out", 32'(bus.b_vld_out), 32'(e_bvld));
        chk("res",       32'(bus.res),       32'(e_res));
        chk("res_vld",   32'(bus.res_vld),   32'(e_vld));
        chk("ovr",       32'(bus.ovr),       32'(e_ovr));
`ifdef SYSTOLIC_PE_STATUS_EN
        chk("res_flag",  32'(bus.res_flag),  32'(e_flag));
`endif
    endtask

    task automatic cycle();
        model_edge();
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic drive(input int a, input int b, input bit av, input bit bv);
        bus.a_in     = 8'(a);
        bus.b_in     = 8'(b);
        bus.a_vld_in = av;
        bus.b_vld_in = bv;
        cycle();
        bus.a_vld_in = 1'b0;
        bus.b_vld_in = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 1'b0, 1'b0);
    endtask

    task automatic pairs4(input int a0, input int b0, input int a1, input int b1,
                          input int a2, input int b2, input int a3, input int b3);
        drive(a0, b0, 1'b1, 1'b1);
        drive(a1, b1, 1'b1, 1'b1);
        drive(a2, b2, 1'b1, 1'b1);
        drive(a3, b3, 1'b1, 1'b1);
    endtask

    initial begin
        bus.a_in = '0; bus.a_vld_in = 1'b0;
        bus.b_in = '0; bus.b_vld_in = 1'b0;
        bus.mode = 2'd0; bus.clear = 1'b0; bus.res_rdy = 1'b1;

        // reset state
        reset = 1'b1;
        cycle();
        cycle();
        chk("rst_res", 32'(bus.res), 0);
        chk("rst_vld", 32'(bus.res_vld), 0);
        chk("rst_ovr", 32'(bus.ovr), 0);
        reset = 1'b0;
        idle(1);

        // mode 0 wrap MAC
        pairs4(3, 4, 5, 6, 7, 8, 1, 2);
        chk("m0_res", 32'(bus.res), 100);
        chk("m0_vld", 32'(bus.res_vld), 1);
        idle(1);
        chk("m0_vld_1cyc", 32'(bus.res_vld), 0);

        // saturating and wrapping on large products
        bus.mode = 2'd1;
        pairs4(255, 255, 255, 255, 255, 255, 255, 255);
        chk("m1_sat", 32'(bus.res), 65535);
`ifdef SYSTOLIC_PE_STATUS_EN
        chk("m1_flag", 32'(bus.res_flag), 1);
`endif
        bus.mode = 2'd0;
        pairs4(255, 255, 255, 255, 255, 255, 255, 255);
        chk("m0_wrap", 32'(bus.res), 63492);
`ifdef SYSTOLIC_PE_STATUS_EN
        chk("m0_flag", 32'(bus.res_flag), 1);
`endif

        // min-plus / max-plus
        bus.mode = 2'd2;
        pairs4(10, 5, 3, 20, 7, 7, 100, 1);
        chk("m2_min", 32'(bus.res), 14);
        bus.mode = 2'd3;
        pairs4(10, 5, 3, 20, 7, 7, 100, 1);
        chk("m3_max", 32'(bus.res), 101);

        // mode latched on first pair only
        bus.mode = 2'd2;
        drive(10, 5, 1'b1, 1'b1);
        bus.mode = 2'd0;
        drive(3, 20, 1'b1, 1'b1);
        drive(7, 7, 1'b1, 1'b1);
        drive(100, 1, 1'b1, 1'b1);
        chk("mode_latch", 32'(bus.res), 14);

        // single-sided valids forward without accumulating
        drive(8'hA5, 8'h3C, 1'b1, 1'b0);
        chk("fwd_a", 32'(bus.a_out), 32'h A5);
        chk("fwd_avld", 32'(bus.a_vld_out), 1);
        drive(8'h11, 8'h77, 1'b0, 1'b1);
        chk("fwd_b", 32'(bus.b_out), 32'h77);
        pairs4(2, 2, 2, 2, 2, 2, 2, 2);
        chk("single_side", 32'(bus.res), 16);

        // clear mid-accumulation, with a same-cycle pair that must be dropped
        drive(9, 9, 1'b1, 1'b1);
        drive(9, 9, 1'b1, 1'b1);
        bus.clear = 1'b1;
        drive(50, 50, 1'b1, 1'b1);
        chk("clr_fwd", 32'(bus.b_out), 50);
        bus.clear = 1'b0;
        pairs4(1, 1, 1, 1, 1, 1, 1, 1);
        chk("clear_res", 32'(bus.res), 4);

        // clear coinciding with the K-th pair suppresses the result
        idle(1);
        drive(2, 2, 1'b1, 1'b1);
        drive(2, 2, 1'b1, 1'b1);
        drive(2, 2, 1'b1, 1'b1);
        bus.clear = 1'b1;
        drive(2, 2, 1'b1, 1'b1);
        bus.clear = 1'b0;
        chk("clr_kth_vld", 32'(bus.res_vld), 0);

        // reset mid-accumulation
        drive(1, 1, 1'b1, 1'b1);
        drive(1, 1, 1'b1, 1'b1);
        drive(1, 1, 1'b1, 1'b1);
        reset = 1'b1;
        drive(1, 1, 1'b1, 1'b1);
        reset = 1'b0;
        chk("rst_mid_vld", 32'(bus.res_vld), 0);
        chk("rst_mid_aout", 32'(bus.a_out), 0);
        idle(2);
        pairs4(2, 3, 2, 3, 2, 3, 2, 3);
        chk("rst_mid_res", 32'(bus.res), 24);
        idle(1);

        // overrun
        bus.res_rdy = 1'b0;
        pairs4(3, 4, 5, 6, 7, 8, 1, 2);
        chk("ovr_first", 32'(bus.res), 100);
        chk("ovr_clear0", 32'(bus.ovr), 0);
        pairs4(1, 1, 1, 1, 1, 1, 1, 1);
        chk("ovr_res", 32'(bus.res), 4);
        chk("ovr_set", 32'(bus.ovr), 1);
        chk("ovr_vld", 32'(bus.res_vld), 1);
        bus.res_rdy = 1'b1;
        idle(1);
        chk("ovr_drain", 32'(bus.res_vld), 0);
        chk("ovr_sticky", 32'(bus.ovr), 1);

        // randomized traffic against the model
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        for (int i = 0; i < 600; i++) begin
            bus.a_in     = 8'($urandom);
            bus.b_in     = 8'($urandom);
            bus.a_vld_in = ($urandom_range(0, 3) != 0);
            bus.b_vld_in = ($urandom_range(0, 3) != 0);
            bus.mode     = 2'($urandom);
            bus.clear    = ($urandom_range(0, 31) == 0);
            bus.res_rdy  = ($urandom_range(0, 1) == 1);
            reset        = ($urandom_range(0, 149) == 0);
            cycle();
        end
        reset = 1'b0;
        bus.clear = 1'b0;
        bus.res_rdy = 1'b1;
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
